// File: rtl/mem_stage_lsu.sv
// Stage-4 load/store unit: valid/ready between execute and writeback, one
// outstanding access on a req/gnt/rvalid memory port, lane-aligned stores and extended loads.
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int PASS_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_base,
  input  logic [11:0]         in_offset,
  input  logic [XLEN-1:0]     in_store_data,
  input  logic [PASS_W-1:0]   in_pass,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_load_data,
  output logic                out_fault,
  output logic [PASS_W-1:0]   out_pass,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);
  localparam int NB  = XLEN / 8;
  localparam int LOW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  logic [1:0]        state;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [NB-1:0]     r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [2:0]        r_f3;
  logic [LOW-1:0]    r_lo;
  logic [PASS_W-1:0] r_pass;

  logic [XLEN-1:0]   ea, addr_n, wdata_n;
  logic [LOW-1:0]    lo;
  logic [3:0]        size, amask;
  logic [NB-1:0]     lane_mask, be_n;
  logic              legal, misal, is_mem, fault, accept, out_free;

  // Decode of the incoming request.
  always_comb begin
    ea        = in_base + {{(XLEN-12){in_offset[11]}}, in_offset};
    lo        = ea[LOW-1:0];
    size      = 4'd1;
    legal     = 1'b1;
    lane_mask = NB'(8'h01);
    case (in_funct3)
      3'b000, 3'b100: begin size = 4'd1; lane_mask = NB'(8'h01); end
      3'b001, 3'b101: begin size = 4'd2; lane_mask = NB'(8'h03); end
      3'b010:         begin size = 4'd4; lane_mask = NB'(8'h0F); end
      3'b110:         begin size = 4'd4; lane_mask = NB'(8'h0F); legal = (XLEN == 64); end
      3'b011:         begin size = 4'd8; lane_mask = NB'(8'hFF); legal = (XLEN == 64); end
      default:        legal = 1'b0;
    endcase
    amask   = size - 4'd1;
    misal   = (ea[3:0] & amask) != 4'd0;
    is_mem  = (in_op == 2'b01) || (in_op == 2'b10);
    fault   = is_mem && (!legal || misal);
    addr_n  = ea;
    addr_n[LOW-1:0] = '0;
    be_n    = lane_mask << lo;
    wdata_n = in_store_data << {lo, 3'b000};
  end

  assign out_free = !out_valid || out_ready;
  assign in_ready = !rst && (state == S_IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // Lane extraction from the registered lane offset and funct3.
  logic [XLEN-1:0] sh, ext;
  always_comb begin
    sh = mem_rdata >> {r_lo, 3'b000};
    case (r_f3)
      3'b000:  ext = XLEN'($signed(sh[7:0]));
      3'b100:  ext = XLEN'(sh[7:0]);
      3'b001:  ext = XLEN'($signed(sh[15:0]));
      3'b101:  ext = XLEN'(sh[15:0]);
      3'b010:  ext = XLEN'($signed(sh[31:0]));
      3'b110:  ext = XLEN'(sh[31:0]);
      default: ext = sh;
    endcase
  end

  // Output register load: at most one source per cycle since the FSM is blocking.
  logic              load_out, nxt_fault;
  logic [XLEN-1:0]   nxt_data;
  logic [PASS_W-1:0] nxt_pass;
  always_comb begin
    load_out  = 1'b0;
    nxt_fault = 1'b0;
    nxt_data  = '0;
    nxt_pass  = r_pass;
    case (state)
      S_IDLE: if (accept && (!is_mem || fault)) begin
        load_out  = 1'b1;
        nxt_fault = fault;
        nxt_pass  = in_pass;
      end
      S_REQ:  if (mem_gnt && r_we) load_out = 1'b1;
      S_RSP:  if (mem_rvalid) begin
        load_out = 1'b1;
        nxt_data = ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_be          <= '0;
      r_wdata       <= '0;
      r_f3          <= '0;
      r_lo          <= '0;
      r_pass        <= '0;
      out_valid     <= 1'b0;
      out_fault     <= 1'b0;
      out_load_data <= '0;
      out_pass      <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          r_we    <= (in_op == 2'b10);
          r_addr  <= addr_n;
          r_be    <= be_n;
          r_wdata <= (in_op == 2'b10) ? wdata_n : '0;
          r_f3    <= in_funct3;
          r_lo    <= lo;
          r_pass  <= in_pass;
          if (is_mem && !fault) state <= S_REQ;
        end
        S_REQ:  if (mem_gnt) state <= r_we ? S_IDLE : S_RSP;
        S_RSP:  if (mem_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (load_out) begin
        out_valid     <= 1'b1;
        out_fault     <= nxt_fault;
        out_load_data <= nxt_data;
        out_pass      <= nxt_pass;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Port fields come from registers and are zeroed outside REQ.
  assign mem_req   = (state == S_REQ);
  assign mem_we    = mem_req && r_we;
  assign mem_addr  = mem_req ? r_addr  : '0;
  assign mem_be    = mem_req ? r_be    : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a 32-bit instance for most vectors and a
// 64-bit instance for LWU.
module tb_mem_stage_lsu;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_ready, gnt, rvalid;
  logic [1:0]  op;
  logic [2:0]  f3;
  logic [31:0] base, sd, rdata;
  logic [11:0] off;
  logic [63:0] pass;
  logic        out_valid, out_fault, mem_req, mem_we;
  logic [31:0] out_data, mem_addr, mem_wdata;
  logic [63:0] out_pass;
  logic [3:0]  mem_be;

  logic        in_valid64, in_ready64, out_valid64, out_fault64, mem_req64, mem_we64;
  logic [63:0] base64, sd64, rdata64, out_data64, out_pass64, mem_addr64, mem_wdata64;
  logic [7:0]  mem_be64;

  mem_stage_lsu #(.XLEN(32), .PASS_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(op),
    .in_funct3(f3), .in_base(base), .in_offset(off), .in_store_data(sd), .in_pass(pass),
    .out_valid(out_valid), .out_ready(out_ready), .out_load_data(out_data),
    .out_fault(out_fault), .out_pass(out_pass), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(gnt),
    .mem_rvalid(rvalid), .mem_rdata(rdata));

  mem_stage_lsu #(.XLEN(64), .PASS_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .in_op(op),
    .in_funct3(f3), .in_base(base64), .in_offset(off), .in_store_data(sd64), .in_pass(pass),
    .out_valid(out_valid64), .out_ready(out_ready), .out_load_data(out_data64),
    .out_fault(out_fault64), .out_pass(out_pass64), .mem_req(mem_req64), .mem_we(mem_we64),
    .mem_addr(mem_addr64), .mem_be(mem_be64), .mem_wdata(mem_wdata64), .mem_gnt(gnt),
    .mem_rvalid(rvalid), .mem_rdata(rdata64));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [2:0] f, input logic [31:0] b,
                       input logic [11:0] of, input logic [31:0] d, input logic [63:0] p);
    op = o; f3 = f; base = b; off = of; sd = d; pass = p; in_valid = 1'b1;
  endtask

  // Load with gnt in cycle 1 and rvalid in cycle 2; result expected in cycle 3.
  task automatic do_load(input string tag, input logic [2:0] f, input logic [31:0] b,
                         input logic [11:0] of, input logic [31:0] rd, input logic [31:0] exp);
    drive(2'b01, f, b, of, 32'h0, 64'h0);
    gnt = 1'b1; rdata = rd;
    step(); in_valid = 1'b0;
    step(); gnt = 1'b0; rvalid = 1'b1;
    chk({tag, "_wait"}, out_valid, 1'b0);
    step(); rvalid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp);
    step();
  endtask

  // Faulting access: result in cycle 1, never a request.
  task automatic do_fault(input string tag, input logic [2:0] f, input logic [31:0] b,
                          input logic [11:0] of);
    drive(2'b01, f, b, of, 32'h0, 64'h0);
    step(); in_valid = 1'b0;
    chk({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_fault"}, out_fault, 1'b1);
    chk({tag, "_data"}, out_data, 32'h0);
    step();
    chk({tag, "_req2"}, mem_req, 1'b0);
  endtask

  initial begin
    in_valid = 1'b1; in_valid64 = 1'b0; out_ready = 1'b1; gnt = 1'b0; rvalid = 1'b0;
    op = 2'b00; f3 = 3'b000; base = 32'h0; off = 12'h0; sd = 32'h0; pass = 64'hDEAD;
    rdata = 32'h0; base64 = 64'h0; sd64 = 64'h0; rdata64 = 64'h0;

    // Reset with in_valid held high
    step(); step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_out_pass", out_pass, 64'h0);
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    step();

    // SB to 0x1003
    drive(2'b10, 3'b000, 32'h1001, 12'd2, 32'h000000A5, 64'h0);
    gnt = 1'b1;
    step(); in_valid = 1'b0;
    chk("sb_req", mem_req, 1'b1);
    chk("sb_we", mem_we, 1'b1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hA500_0000);
    chk("sb_in_ready", in_ready, 1'b0);
    step(); gnt = 1'b0;
    chk("sb_valid", out_valid, 1'b1);
    chk("sb_fault", out_fault, 1'b0);
    chk("sb_data", out_data, 32'h0);
    chk("sb_idle_addr", mem_addr, 32'h0);
    step();
    chk("sb_drain", out_valid, 1'b0);

    // SW with negative offset: 0x1010 - 4
    drive(2'b10, 3'b010, 32'h1010, 12'hFFC, 32'h1234_5678, 64'h0);
    gnt = 1'b1;
    step(); in_valid = 1'b0;
    chk("sw_addr", mem_addr, 32'h100C);
    chk("sw_be", mem_be, 4'b1111);
    chk("sw_wdata", mem_wdata, 32'h1234_5678);
    step(); gnt = 1'b0;
    chk("sw_valid", out_valid, 1'b1);
    step();

    // LB at 0x2002, gnt in cycle 3, rvalid in cycle 5, result in cycle 6
    drive(2'b01, 3'b000, 32'h2000, 12'd2, 32'h0, 64'h0);
    rdata = 32'h0080_0000;
    step(); in_valid = 1'b0;
    chk("lb_req", mem_req, 1'b1);
    chk("lb_we", mem_we, 1'b0);
    chk("lb_addr", mem_addr, 32'h2000);
    chk("lb_be", mem_be, 4'b0100);
    chk("lb_wdata", mem_wdata, 32'h0);
    step();
    step(); gnt = 1'b1;
    chk("lb_req_held", mem_req, 1'b1);
    step(); gnt = 1'b0;
    chk("lb_rsp_noreq", mem_req, 1'b0);
    step(); rvalid = 1'b1;
    chk("lb_c5", out_valid, 1'b0);
    step(); rvalid = 1'b0;
    chk("lb_valid", out_valid, 1'b1);
    chk("lb_data", out_data, 32'hFFFF_FF80);
    step();

    do_load("lbu", 3'b100, 32'h2000, 12'd2, 32'h0080_0000, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h2000, 12'd2, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h2000, 12'd2, 32'h8001_0000, 32'h0000_8001);

    do_fault("lw_mis", 3'b010, 32'h3000, 12'd2);
    do_fault("ld_x32", 3'b011, 32'h3000, 12'd0);
    do_fault("lwu_x32", 3'b110, 32'h3000, 12'd0);

    // Reserved op behaves as non-memory
    drive(2'b11, 3'b111, 32'h0, 12'd1, 32'h0, 64'h77);
    step(); in_valid = 1'b0;
    chk("rsv_valid", out_valid, 1'b1);
    chk("rsv_fault", out_fault, 1'b0);
    chk("rsv_pass", out_pass, 64'h77);
    chk("rsv_req", mem_req, 1'b0);
    step();

    // Back-to-back non-memory ops with backpressure
    drive(2'b00, 3'b000, 32'h0, 12'd0, 32'h0, 64'd1);
    step();
    chk("bp_p1", out_pass, 64'd1);
    out_ready = 1'b0; pass = 64'd2; #1;
    chk("bp_in_ready_stall", in_ready, 1'b0);
    step();
    chk("bp_hold_valid", out_valid, 1'b1);
    chk("bp_hold_p1", out_pass, 64'd1);
    out_ready = 1'b1; #1;
    chk("bp_in_ready_free", in_ready, 1'b1);
    step();
    chk("bp_p2", out_pass, 64'd2);
    pass = 64'd3;
    step(); in_valid = 1'b0;
    chk("bp_p3", out_pass, 64'd3);
    step();
    chk("bp_drain", out_valid, 1'b0);

    // Reset during RSP, then a late rvalid
    drive(2'b01, 3'b010, 32'h5000, 12'd0, 32'h0, 64'h0);
    gnt = 1'b1; rdata = 32'h1234_5678;
    step(); in_valid = 1'b0;
    chk("rr_req", mem_req, 1'b1);
    step(); gnt = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; rvalid = 1'b1;
    chk("rr_valid0", out_valid, 1'b0);
    chk("rr_req0", mem_req, 1'b0);
    step();
    chk("rr_valid1", out_valid, 1'b0);
    rvalid = 1'b0;
    step();
    chk("rr_valid2", out_valid, 1'b0);

    // XLEN=64 LWU at 0x4004
    op = 2'b01; f3 = 3'b110; base64 = 64'h4000; off = 12'd4; in_valid64 = 1'b1;
    gnt = 1'b1; rdata64 = 64'h8000_0001_0000_0000;
    step(); in_valid64 = 1'b0;
    chk("lwu64_addr", mem_addr64, 64'h4000);
    chk("lwu64_be", mem_be64, 8'hF0);
    step(); gnt = 1'b0; rvalid = 1'b1;
    step(); rvalid = 1'b0;
    chk("lwu64_valid", out_valid64, 1'b1);
    chk("lwu64_fault", out_fault64, 1'b0);
    chk("lwu64_data", out_data64, 64'h0000_0000_8000_0001);
    chk("lwu64_x32_quiet", out_valid, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised load/store unit for pipeline stage 4, the successor to the single-cycle memory stage. It sits between execute and writeback on valid/ready handshakes. It drives a variable-latency memory port (req/gnt/rvalid) with lane-aligned byte enables and store data. Loads are sign/zero-extended, and misaligned or unsupported accesses are reported as faults.

## Interface
Parameters:
- XLEN, 32: data/address width; legal values 32 or 64.
- PASS_W, 64: width of the sideband carried unchanged to writeback (alu_result, rd, etc.).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept
- in_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- in_funct3  in  3  RISC-V load/store funct3
- in_base  in  XLEN  rs1 value
- in_offset  in  12  signed immediate
- in_store_data  in  XLEN  rs2 value
- in_pass  in  PASS_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  writeback can accept
- out_load_data  out  XLEN  extended load data; 0 for non-loads and faults
- out_fault  out  1  misaligned or unsupported access
- out_pass  out  PASS_W  sideband copy
- mem_req  out  1  request
- mem_we  out  1  write
- mem_addr  out  XLEN  byte address, low log2(XLEN/8) bits forced to 0
- mem_be  out  XLEN/8  byte lanes
- mem_wdata  out  XLEN  lane-shifted store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data

## Operation
- Effective address: ea = in_base + sext(in_offset), computed modulo 2^XLEN. Lane offset: lo = ea[log2(XLEN/8)-1:0].
- Access size:
  - B (000/100): 1 byte.
  - H (001/101): 2 bytes.
  - W (010; 110 = LWU): 4 bytes.
  - D (011): 8 bytes.
  - LWU and D are legal only when XLEN = 64. Any other funct3 is a fault.
- Misaligned when ea mod size != 0, which is a fault. A faulting access issues no memory request.
- Store lanes: mem_be = ((1<<size)-1) << lo. mem_wdata = in_store_data << (8*lo); unused lanes are 0.
- Load extraction: shift mem_rdata right by 8*lo, then truncate to size. Unsigned variants (100, 101, 110) zero-extend; the others sign-extend.
- FSM states:
  - IDLE: on accept, capture all inputs. Faults and non-memory ops load the output register directly; memory ops go to REQ.
  - REQ: mem_req=1 with stable registered mem_* until mem_gnt. On gnt, a store writes the output register and returns to IDLE; a load goes to RSP.
  - RSP: mem_req=0. On mem_rvalid, capture the extended data into the output register and return to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- The output register holds its value while out_valid && !out_ready. It is cleared to out_valid=0 on out_ready when no new result is loaded.
- mem_rvalid outside RSP is ignored. mem_gnt outside REQ is ignored.
- When not in REQ: mem_we, mem_addr, mem_be and mem_wdata are all 0.

## Timing
- Reset values: state IDLE; out_valid, out_fault, out_load_data, out_pass all 0; mem_req and every mem_* output 0.
- Reset mid-transaction abandons the access at once, with no output produced. A late rvalid after reset is ignored.
- Latency, measured from the accept edge at cycle 0:
  - Non-memory op or fault: out_valid in cycle 1.
  - Store with gnt in cycle 1: out_valid in cycle 2.
  - Load with gnt in cycle 1 and rvalid in cycle 2: out_valid in cycle 3.
  - Each extra wait cycle on gnt or rvalid adds one cycle.
- rvalid is never expected in the same cycle as gnt. The earliest legal rvalid is the cycle after gnt.
- Throughput: one non-memory op per cycle while out_ready=1. Memory ops are blocking, with one outstanding access.
- Output backpressure (out_ready=0) holds out_* stable and keeps in_ready=0. It does not stall an already-issued memory access, but completion waits for the output register to be free.

## Test plan
- Reset with in_valid=1 and rst=1 for 2 cycles -> all outputs 0 and in_ready=0 during reset; in_ready=1 in the first cycle after rst falls.
- SB, XLEN=32, base=0x1001, offset=2, data=0xA5 -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xA5000000, mem_we=1; out_valid two cycles after accept with gnt immediate.
- LB at ea=0x2002, mem_rdata=0x0080_0000 with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> out_load_data=0xFFFFFF80, out_valid 6 cycles after accept. LBU at the same address -> 0x00000080.
- LW at ea=0x3002 (misaligned) -> mem_req never asserted, out_fault=1, out_load_data=0, out_valid in cycle 1. LD with XLEN=32 -> same fault.
- XLEN=64, LWU at ea=0x4004 with mem_rdata=0x8000_0001_0000_0000 -> out_load_data=0x0000_0000_8000_0001.
- Back-to-back non-memory ops with out_ready toggling 1,0,1 and in_pass=1,2,3 -> out_pass sequence 1,2,3, with no loss or duplication and no change to out_pass while stalled. A reset asserted during RSP, followed by rvalid -> no out_valid.
